// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Parametrised VGA raster timing generator running on the 100 MHz board
// clock. A free-running divider produces a one-cycle pixel clock-enable
// (pix_ce); every other piece of state advances only on that enable.
//
// A second pair of "lead" counters runs the same raster PIPE_LAT pixels
// ahead of hcount/vcount and drives the framebuffer read address. Read
// data therefore arrives exactly when the main counters reach the pixel
// it belongs to. The output stage registers sync, blank and colour one
// pixel after the counters.
//
// Ports
//   CLK100MHZ   in   system clock, all logic on its rising edge
//   CPU_RESETN  in   synchronous active-low reset
//   mode        in   0=framebuffer 1=colour bars 2=checker 3=solid blue,
//                    latched once per frame at the last pixel
//   raddr_vga   out  framebuffer read address (lead position)
//   rdata_vga   in   RGB444 data for the address issued PIPE_LAT ticks ago
//   VGA_R/G/B   out  4-bit colour outputs, zero while blanked
//   VGA_HS/VS   out  sync outputs, active level SYNC_POL
//   blank       out  1 outside the visible area, aligned with colour
//   hcount      out  current column (before the output register)
//   vcount      out  current line (before the output register)
//   frame_start out  one-cycle pulse on the tick that wraps to (0,0)
//   pix_ce      out  pixel clock-enable
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = 19,
    parameter int PIPE_LAT = 2
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] raddr_vga,
    input  logic [11:0]       rdata_vga,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              blank,
    output logic [10:0]       hcount,
    output logic [10:0]       vcount,
    output logic              frame_start,
    output logic              pix_ce
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] LEAD_H0  = 11'(PIPE_LAT);

    // ------------------------------------------------------------------
    // Pixel clock-enable
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign pix_ce = (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (hcount == H_LAST);
    assign v_wrap = (vcount == V_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                hcount <= '0;
                vcount <= v_wrap ? 11'd0 : vcount + 11'd1;
            end else begin
                hcount <= hcount + 11'd1;
            end
        end
    end

    assign frame_start = pix_ce && h_wrap && v_wrap;

    // ------------------------------------------------------------------
    // Lead counters and read address. While the lead position is visible
    // raddr_vga equals lead_v*H_ACTIVE + lead_h, so the data for a pixel
    // lands on rdata_vga exactly when hcount/vcount reach that pixel.
    // ------------------------------------------------------------------
    logic [10:0] lead_h;
    logic [10:0] lead_v;
    logic        lead_active;
    logic        lead_h_wrap;
    logic        lead_frame_wrap;

    assign lead_active     = (lead_h < H_ACT) && (lead_v < V_ACT);
    assign lead_h_wrap     = (lead_h == H_LAST);
    assign lead_frame_wrap = lead_h_wrap && (lead_v == V_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            lead_h    <= LEAD_H0;
            lead_v    <= '0;
            raddr_vga <= ADDR_W'(PIPE_LAT);
        end else if (pix_ce) begin
            if (lead_h_wrap) begin
                lead_h <= '0;
                lead_v <= (lead_v == V_LAST) ? 11'd0 : lead_v + 11'd1;
            end else begin
                lead_h <= lead_h + 11'd1;
            end

            if (lead_frame_wrap) begin
                raddr_vga <= '0;
            end else if (lead_active) begin
                raddr_vga <= raddr_vga + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode register: updated only on the frame wrap tick so a whole frame
    // is always drawn with one pattern.
    // ------------------------------------------------------------------
    logic [1:0] mode_q;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            mode_q <= 2'd0;
        end else if (frame_start) begin
            mode_q <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Pattern selection
    // ------------------------------------------------------------------
    logic        active;
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    logic [11:0] pattern;

    assign active = (hcount < H_ACT) && (vcount < V_ACT);

    // Bar index by threshold compare; columns past 7*BAR_W fall into the
    // last bar, which absorbs any remainder of H_ACTIVE/8.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= 11'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx)
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_comb begin
        pattern = 12'h000;
        case (mode_q)
            2'd0: pattern = rdata_vga;
            2'd1: pattern = bar_rgb;
            2'd2: pattern = (hcount[5] ^ vcount[5]) ? 12'hFFF : 12'h000;
            default: pattern = 12'h00F;
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage: one pixel behind the counters
    // ------------------------------------------------------------------
    logic [11:0] rgb_q;
    logic        in_hsync;
    logic        in_vsync;

    assign in_hsync = (hcount >= HS_START) && (hcount < HS_END);
    assign in_vsync = (vcount >= VS_START) && (vcount < VS_END);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            VGA_HS <= ~SYNC_POL;
            VGA_VS <= ~SYNC_POL;
            blank  <= 1'b1;
            rgb_q  <= 12'h000;
        end else if (pix_ce) begin
            VGA_HS <= in_hsync ? SYNC_POL : ~SYNC_POL;
            VGA_VS <= in_vsync ? SYNC_POL : ~SYNC_POL;
            blank  <= ~active;
            rgb_q  <= active ? pattern : 12'h000;
        end
    end

    assign VGA_R = rgb_q[11:8];
    assign VGA_G = rgb_q[7:4];
    assign VGA_B = rgb_q[3:0];

endmodule
